dp_rr_sched: RTL

//  Round-robin scheduler sharing one enable/data datapath unit (enin/din -> enout/dout)

---
 rtl/dp_rr_sched_if.sv | 44 ++++
 rtl/dp_rr_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_rr_sched_if.sv
// ---------------------------------------------------------------------------
// dp_rr_sched_if
// Bundles the requester-side handshake, the shared datapath unit port and the
// response bus of the round-robin scheduler.
//
// Signals:
//   req_vld  [N]    per-requester request valid
//   req_data [N*W]  per-requester payload, slice i = [i*W +: W]
//   req_rdy  [N]    one-hot grant back to the requesters
//   dp_enin         enable into the shared unit
//   dp_din   [W]    data into the shared unit
//   dp_enout        shared unit response valid
//   dp_dout  [W]    shared unit response data
//   rsp_vld  [N]    one-hot response valid to the issuing requester
//   rsp_data [W]    shared response data bus
//
// Modports:
//   slave  - the scheduler itself
//   master - the environment (requesters plus the shared unit)
// ---------------------------------------------------------------------------
interface dp_rr_sched_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic [N-1:0]   req_vld;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_rdy;
    logic           dp_enin;
    logic [W-1:0]   dp_din;
    logic           dp_enout;
    logic [W-1:0]   dp_dout;
    logic [N-1:0]   rsp_vld;
    logic [W-1:0]   rsp_data;

    modport slave (
        input  req_vld, req_data, dp_enout, dp_dout,
        output req_rdy, dp_enin, dp_din, rsp_vld, rsp_data
    );

    modport master (
        output req_vld, req_data, dp_enout, dp_dout,
        input  req_rdy, dp_enin, dp_din, rsp_vld, rsp_data
    );
endinterface

// File: rtl/dp_rr_sched.sv
// ---------------------------------------------------------------------------
// dp_rr_sched
// Round-robin scheduler that shares one enable/data datapath unit among N
// requesters. One request is granted per cycle and forwarded (registered) to
// the unit; the index of each granted requester is kept in an in-order tag
// FIFO so that every unit response can be routed back to its issuer.
//
// Parameters:
//   N        number of requesters (2..8)
//   W        data width of requests, unit data and responses
//   MAX_OUT  max in-flight transfers (tag FIFO depth, power of 2, >= 2)
//
// Ports:
//   ck          clock, all state on posedge
//   rst_n       asynchronous active-low reset
//   flush       level; stop granting and drain outstanding transfers
//   busy        FSM not IDLE or transfers still in flight
//   err_orphan  sticky; a unit response arrived with no transfer in flight
//   bus         dp_rr_sched_if.slave (request / unit / response signals)
//   stats_clr   (STATS build only) pulse clearing the grant counters
//   grant_cnt   (STATS build only) N x 16-bit saturating grant counters
//
// Optional feature: define DP_RR_SCHED_STATS_EN to add the per-requester
// grant counters and their clear input.
// ---------------------------------------------------------------------------
module dp_rr_sched #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int MAX_OUT = 4
) (
    input  logic            ck,
    input  logic            rst_n,
    input  logic            flush,
`ifdef DP_RR_SCHED_STATS_EN
    input  logic            stats_clr,
    output logic [N*16-1:0] grant_cnt,
`endif
    output logic            busy,
    output logic            err_orphan,
    dp_rr_sched_if.slave    bus
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [IW-1:0]  tag_q [MAX_OUT];

    logic           dp_enin_q;
    logic [W-1:0]   dp_din_q;
    logic [N-1:0]   rsp_vld_q;
    logic [W-1:0]   rsp_data_q;
    logic           err_orphan_q;

    logic           any_req;
    logic           grant_ok;
    logic           grant_any;
    logic [IW-1:0]  grant_idx;
    logic [N-1:0]   grant_vec;
    logic [W-1:0]   grant_data;
    logic [IW:0]    cand;
    logic           push, pop, orphan;

    assign any_req = |bus.req_vld;

    // Granting is allowed in ARB, and in IDLE on the cycle the FSM leaves for
    // ARB (which is exactly "some request and no flush", both also required
    // below). The registered count gates grants, so a full FIFO never grants
    // even if a response frees a slot in the same cycle. Holding off while
    // rst_n is low keeps req_rdy at 0 during reset.
    always_comb begin
        grant_ok = rst_n && !flush && (count_q != CW'(MAX_OUT)) &&
                   ((state_q == ARB) || (state_q == IDLE));
    end

    // Round-robin search: first valid request starting at ptr_q, wrapping
    // modulo N. cand never exceeds 2N-2, so one conditional subtract is enough.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!grant_any && grant_ok && bus.req_vld[cand[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

    // One-hot grant vector and the payload of the granted requester.
    always_comb begin
        grant_vec  = '0;
        grant_data = '0;
        if (grant_any) begin
            grant_vec = N'(1) << grant_idx;
        end
        for (int i = 0; i < N; i++) begin
            if (grant_idx == IW'(i)) begin
                grant_data = bus.req_data[i*W +: W];
            end
        end
    end

    assign bus.req_rdy = grant_vec;

    // A response pops the FIFO head only if something is in flight; a
    // response with nothing outstanding is dropped and flagged as orphan.
    assign push   = grant_any;
    assign pop    = bus.dp_enout && (count_q != '0);
    assign orphan = bus.dp_enout && (count_q == '0);

    // Next-state logic for the FSM; flush wins over new requests.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if (any_req) begin
                    state_d = ARB;
                end
            end
            ARB: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if (!any_req && (count_q == '0)) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (!flush && (count_q == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pointer moves just past the granted requester; count tracks pushes and
    // pops, staying unchanged when both happen in one cycle.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (grant_any) begin
            ptr_d = (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state: FSM, round-robin pointer, in-flight count, FIFO pointers.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Tag storage; pointers wrap naturally because MAX_OUT is a power of 2.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                tag_q[i] <= '0;
            end
        end else if (push) begin
            tag_q[wr_ptr_q] <= grant_idx;
        end
    end

    // Registered unit input and response outputs. dp_din and rsp_data keep
    // their last value on idle cycles; the orphan flag is sticky until reset.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            dp_enin_q    <= 1'b0;
            dp_din_q     <= '0;
            rsp_vld_q    <= '0;
            rsp_data_q   <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            dp_enin_q <= grant_any;
            if (grant_any) begin
                dp_din_q <= grant_data;
            end
            if (pop) begin
                rsp_vld_q  <= N'(1) << tag_q[rd_ptr_q];
                rsp_data_q <= bus.dp_dout;
            end else begin
                rsp_vld_q  <= '0;
            end
            if (orphan) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    assign bus.dp_enin  = dp_enin_q;
    assign bus.dp_din   = dp_din_q;
    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_data = rsp_data_q;
    assign err_orphan   = err_orphan_q;
    assign busy         = (state_q != IDLE) || (count_q != '0);

`ifdef DP_RR_SCHED_STATS_EN
    logic [15:0] grant_cnt_q [N];

    // Per-requester saturating grant counters. A clear that coincides with a
    // grant loads 1 so that grant is not lost.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (stats_clr) begin
                    grant_cnt_q[i] <= grant_vec[i] ? 16'd1 : 16'd0;
                end else if (grant_vec[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N; i++) begin
            grant_cnt[i*16 +: 16] = grant_cnt_q[i];
        end
    end
`endif

endmodule
